// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver with a single-byte ready/valid holding
// register. Detects framing errors, rejects false starts (start bit must
// still be low at mid-bit), and reports overrun when a byte completes while
// the holding register is still occupied.
module uart_rx_frontend #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME) + 1;

  // Terminal timer counts; the timer starts at 0 on state entry.
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             sync1;
  logic             rx_s;
  logic [CNT_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Control strobes produced by the next-state logic.
  logic timer_clear;
  logic bit_clear;
  logic shift_en;
  logic stop_ok;
  logic stop_bad;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rx_s  <= sync1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_next  = state;
    timer_clear = 1'b0;
    bit_clear   = 1'b0;
    shift_en    = 1'b0;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
    unique case (state)
      IDLE: begin
        timer_clear = 1'b1;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (timer == SAMPLE_LAST) begin
          timer_clear = 1'b1;
          if (rx_s) begin
            state_next = IDLE;      // glitch: line went back high before mid-bit
          end else begin
            state_next = DATA;
            bit_clear  = 1'b1;
          end
        end
      end
      DATA: begin
        if (timer == SYMBOL_LAST) begin
          timer_clear = 1'b1;
          shift_en    = 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (timer == SYMBOL_LAST) begin
          timer_clear = 1'b1;
          stop_ok     = rx_s;
          stop_bad    = !rx_s;
          state_next  = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // Hold off until the line returns high so a break is one error only.
        timer_clear = 1'b1;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        timer_clear = 1'b1;
        state_next  = IDLE;
      end
    endcase
  end

  // Bit timer, bit index and LSB-first shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
    end else begin
      timer <= timer_clear ? '0 : timer + CNT_W'(1);
      if (bit_clear) bit_idx <= 3'd0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en) shift <= {rx_s, shift[7:1]};
    end
  end

  // Holding register with ready/valid handshake plus error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= 8'd0;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (stop_ok && (!data_out_valid || data_out_ready)) begin
        data_out       <= shift;
        data_out_valid <= 1'b1;
      end else if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
      overrun       <= stop_ok && data_out_valid && !data_out_ready;
      framing_error <= stop_bad;
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend at 10 clocks per bit. Expected
// bytes go into a scoreboard queue as frames are sent; a negedge monitor pops
// and compares on every accepted handshake and counts error pulses.
module tb_uart_rx_frontend;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  int hs_cnt      = 0;  // accepted handshakes
  int ovr_pulses  = 0;  // overrun rising edges
  int ovr_cycles  = 0;  // cycles overrun was high
  int fe_pulses   = 0;
  int fe_cycles   = 0;

  uart_rx_frontend #(
    .CLOCK_FREQ(1_152_000),
    .BAUD_RATE (115_200)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: scoreboard pops, pulse counting, hold-stability check.
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = 8'd0;
  logic       prev_ovr   = 1'b0;
  logic       prev_fe    = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (data_out_valid && data_out_ready) begin
        hs_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%02h, scoreboard empty", data_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data_out !== e) begin
            n_fail++;
            $display("FAIL rx_data: got 0x%02h, expected 0x%02h", data_out, e);
          end else begin
            $display("rx byte 0x%02h ok", data_out);
          end
        end
      end
      if (prev_valid && !prev_ready && data_out_valid) begin
        n_checks++;
        if (data_out !== prev_data) begin
          n_fail++;
          $display("FAIL hold_stable: got 0x%02h, expected 0x%02h", data_out, prev_data);
        end
      end
      if (overrun) ovr_cycles++;
      if (overrun && !prev_ovr) ovr_pulses++;
      if (framing_error) fe_cycles++;
      if (framing_error && !prev_fe) fe_pulses++;
    end
    prev_valid = data_out_valid;
    prev_ready = data_out_ready;
    prev_data  = data_out;
    prev_ovr   = overrun;
    prev_fe    = framing_error;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    wait_clks(10);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      wait_clks(10);
    end
    serial_in = stop_bit;
    wait_clks(10);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    serial_in = 1'b1;
    data_out_ready = 1'b0;
    wait_clks(3);
    n_checks++;
    if (data_out !== 8'd0) begin n_fail++; $display("FAIL reset_data: got 0x%02h, expected 0x00", data_out); end
    n_checks++;
    if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", data_out_valid); end
    n_checks++;
    if (framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b, expected 0", framing_error); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b, expected 0", overrun); end
    rst = 1'b0;
    wait_clks(20);
    $display("test_reset done");
  endtask

  task automatic test_single;
    int lat;
    data_out_ready = 1'b0;
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!data_out_valid && lat < 200) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    n_checks++;
    if (lat - 1 < 97 || lat - 1 > 99) begin
      n_fail++;
      $display("FAIL latency: got %0d clocks, expected 97..99", lat - 1);
    end
    wait_clks(100);
    n_checks++;
    if (data_out_valid !== 1'b1 || data_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_hold: got valid=%b data=0x%02h, expected valid=1 data=0xa5", data_out_valid, data_out);
    end
    data_out_ready = 1'b1;
    wait_clks(1);
    data_out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_clear: got valid=%b, expected 0", data_out_valid); end
    n_checks++;
    if (hs_cnt !== 1) begin n_fail++; $display("FAIL single_hs: got %0d handshakes, expected 1", hs_cnt); end
    wait_clks(5);
    $display("test_single done latency=%0d", lat - 1);
  endtask

  task automatic test_back_to_back;
    int hs0, ov0, fe0;
    hs0 = hs_cnt; ov0 = ovr_cycles; fe0 = fe_cycles;
    data_out_ready = 1'b1;
    exp_q.push_back(8'h00); send_frame(8'h00, 1'b1);
    exp_q.push_back(8'hFF); send_frame(8'hFF, 1'b1);
    exp_q.push_back(8'h3C); send_frame(8'h3C, 1'b1);
    wait_clks(30);
    n_checks++;
    if (hs_cnt - hs0 !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d bytes, expected 3", hs_cnt - hs0); end
    n_checks++;
    if (ovr_cycles != ov0 || fe_cycles != fe0) begin
      n_fail++;
      $display("FAIL b2b_errors: got ovr=%0d fe=%0d cycles, expected 0", ovr_cycles - ov0, fe_cycles - fe0);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_queue: got %0d pending, expected 0", exp_q.size()); end
    $display("test_back_to_back done");
  endtask

  task automatic test_overrun;
    int hs0, op0, oc0;
    hs0 = hs_cnt; op0 = ovr_pulses; oc0 = ovr_cycles;
    data_out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);   // dropped: holding register still full
    wait_clks(20);
    n_checks++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h11) begin
      n_fail++;
      $display("FAIL ovr_hold: got valid=%b data=0x%02h, expected valid=1 data=0x11", data_out_valid, data_out);
    end
    n_checks++;
    if (ovr_pulses - op0 != 1 || ovr_cycles - oc0 != 1) begin
      n_fail++;
      $display("FAIL ovr_pulse: got %0d pulses %0d cycles, expected 1 pulse 1 cycle", ovr_pulses - op0, ovr_cycles - oc0);
    end
    data_out_ready = 1'b1;
    wait_clks(1);
    @(negedge clk);
    n_checks++;
    if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got valid=%b, expected 0", data_out_valid); end
    wait_clks(30);
    n_checks++;
    if (hs_cnt - hs0 != 1) begin n_fail++; $display("FAIL ovr_count: got %0d bytes, expected 1", hs_cnt - hs0); end
    $display("test_overrun done");
  endtask

  task automatic test_framing;
    int hs0, fp0, fc0;
    hs0 = hs_cnt; fp0 = fe_pulses; fc0 = fe_cycles;
    data_out_ready = 1'b1;
    send_frame(8'h55, 1'b0);
    serial_in = 1'b0;
    wait_clks(30);
    serial_in = 1'b1;
    wait_clks(30);
    n_checks++;
    if (fe_pulses - fp0 != 1 || fe_cycles - fc0 != 1) begin
      n_fail++;
      $display("FAIL fe_pulse: got %0d pulses %0d cycles, expected 1 pulse 1 cycle", fe_pulses - fp0, fe_cycles - fc0);
    end
    n_checks++;
    if (hs_cnt != hs0 || data_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fe_nobyte: got %0d bytes valid=%b, expected 0 bytes valid=0", hs_cnt - hs0, data_out_valid);
    end
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    wait_clks(20);
    n_checks++;
    if (hs_cnt - hs0 != 1) begin n_fail++; $display("FAIL fe_recover: got %0d bytes, expected 1", hs_cnt - hs0); end
    $display("test_framing done");
  endtask

  task automatic test_glitch;
    int hs0, fe0;
    hs0 = hs_cnt; fe0 = fe_pulses;
    data_out_ready = 1'b1;
    serial_in = 1'b0;
    wait_clks(3);
    serial_in = 1'b1;
    wait_clks(40);
    n_checks++;
    if (hs_cnt != hs0 || fe_pulses != fe0) begin
      n_fail++;
      $display("FAIL glitch: got %0d bytes %0d errors, expected 0 and 0", hs_cnt - hs0, fe_pulses - fe0);
    end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_clks(20);
    n_checks++;
    if (hs_cnt - hs0 != 1) begin n_fail++; $display("FAIL glitch_recover: got %0d bytes, expected 1", hs_cnt - hs0); end
    $display("test_glitch done");
  endtask

  task automatic test_async_reset;
    int hs0;
    logic [7:0] c3;
    c3 = 8'hC3;
    data_out_ready = 1'b0;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    wait_clks(5);
    // Partial 0xC3: start bit and data bits 0..3, then into bit 4.
    serial_in = 1'b0;
    wait_clks(10);
    for (int i = 0; i < 4; i++) begin
      serial_in = c3[i];
      wait_clks(10);
    end
    serial_in = c3[4];
    wait_clks(4);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (data_out_valid !== 1'b0 || data_out !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b data=0x%02h, expected valid=0 data=0x00", data_out_valid, data_out);
    end
    exp_q.delete();   // held 0x99 is flushed by reset
    wait_clks(2);
    rst = 1'b0;
    serial_in = 1'b1;   // transmitter abandons the frame
    hs0 = hs_cnt;
    data_out_ready = 1'b1;
    wait_clks(150);
    n_checks++;
    if (hs_cnt != hs0 || data_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_spurious: got %0d bytes valid=%b, expected 0 bytes valid=0", hs_cnt - hs0, data_out_valid);
    end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_clks(20);
    n_checks++;
    if (hs_cnt - hs0 != 1) begin n_fail++; $display("FAIL reset_recover: got %0d bytes, expected 1", hs_cnt - hs0); end
    $display("test_async_reset done");
  endtask

  initial begin
    rst = 1'b1;
    serial_in = 1'b1;
    data_out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_glitch();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d undelivered bytes, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Receives 8N1 UART frames from the registered FPGA_SERIAL_RX line and delivers bytes on a ready/valid interface.
- Sits between the top-level serial IOB flop and the CPU's memory-mapped UART data/status registers.
- Adds framing-error detection, false-start rejection and overrun reporting.
- Single holding register; no FIFO.

Parameters:
- CLOCK_FREQ, 125_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- SYMBOL_EDGE_TIME (localparam), CLOCK_FREQ / BAUD_RATE (integer division), clocks per bit.
- SAMPLE_TIME (localparam), SYMBOL_EDGE_TIME / 2, clocks from start-bit falling edge to mid-bit sample.
- CNT_W (localparam), $clog2(SYMBOL_EDGE_TIME)+1, bit-timer width.

Ports:
- clk  input  1  system clock (cpu_clk).
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  raw UART line; idle high.
- data_out  output  8  received byte; stable while data_out_valid=1.
- data_out_valid  output  1  byte available.
- data_out_ready  input  1  consumer accepts byte when high with valid.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while holding register still full.

Behaviour:
- Reset (async assert): state=IDLE, timer=0, bit index=0, shift reg=0.
  - Reset values: data_out=0, data_out_valid=0, framing_error=0, overrun=0.
  - Both synchronizer flops reset to 1.
- Synchronizer:
  - serial_in passes through 2 flops to form rx_s.
  - All decisions use rx_s; fixed 2-cycle input latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rx_s==0 → START, timer cleared.
- START:
  - Timer counts to SAMPLE_TIME-1, then rx_s is sampled.
  - Sample 0 → DATA, timer cleared, bit index=0.
  - Sample 1 (glitch) → IDLE; no outputs change.
- DATA:
  - Every SYMBOL_EDGE_TIME clocks, rx_s is shifted in LSB-first (shift right, new bit into [7]).
  - After bit index 7 is sampled → STOP, timer cleared.
- STOP:
  - After SYMBOL_EDGE_TIME clocks, rx_s is sampled.
  - Sample 1, holding register empty, or emptying this cycle (valid&ready): data_out<=shift reg, data_out_valid<=1 next cycle → IDLE.
  - Sample 1, holding register full and ready=0: new byte dropped, old byte and valid kept, overrun=1 for one cycle → IDLE.
  - Sample 0: byte discarded, framing_error=1 for one cycle → WAIT_IDLE.
- WAIT_IDLE:
  - Stays until rx_s==1, then → IDLE.
  - Prevents a break condition being parsed as repeated frames.
- Handshake:
  - data_out_valid clears on the cycle after valid&ready, unless a new byte loads on that same edge; then it stays 1 with the new data.
  - data_out is held constant while valid=1 and not accepted.
- Latency: data_out_valid rises 2 + SAMPLE_TIME + 9*SYMBOL_EDGE_TIME + 1 clocks after the serial_in falling edge, ±1 clock for edge phase.
- Timer:
  - Saturates never; always cleared on state entry.
  - Comparisons are unsigned at CNT_W bits.
- Reset asserted mid-frame: frame abandoned, all outputs to reset values immediately (async).
  - After deassertion, the block starts at IDLE.
  - If the line is low at that point, the remaining low bits are treated as a new start.
- Back-to-back frames: a start bit immediately after a stop bit (no extra idle) must be received.

Test Plan:
- Bench parameters: CLOCK_FREQ=1_152_000, BAUD_RATE=115_200 → 10 clk/bit, sample at 5.
- Single byte: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop), ready=0 → data_out=0xA5, valid=1, held indefinitely; then ready=1 for one cycle → valid=0 next cycle.
- Back-to-back with ready tied 1: send 0x00, 0xFF, 0x3C with no idle gaps → three valid pulses in order with data 0x00, 0xFF, 0x3C; no overrun, no framing_error.
- Overrun: send 0x11 then 0x22, ready=0 → data_out stays 0x11, overrun pulses exactly 1 cycle at second stop sample.
  - Then ready=1 → valid drops; no 0x22 delivered.
- Framing error: send 0x55 with stop bit 0, line held low 30 clocks then high → framing_error one pulse, valid stays 0, no frame decoded during the low period.
  - Next 0x7E received correctly.
- Glitch: 3-clock low pulse on idle line → no valid, no error; following 0x81 received correctly.
- Async reset mid-frame: assert rst during bit 4 of 0xC3 for 2 clocks → outputs 0 immediately, no spurious byte; following 0x5A received correctly.
